// File: rtl/pipeline_controller_if.sv
// Pipeline control bus: hazard/branch inputs from the datapath and
// advance/flush/bubble controls back to the pipeline registers.
interface pipeline_controller_if #(
  parameter int len    = 32,
  parameter int nb_reg = 5
);
  logic              in_mode_step;
  logic              in_run;
  logic              in_step;
  logic              in_halt;
  logic              in_id_ex_mem_read;
  logic [nb_reg-1:0] in_id_ex_rt;
  logic [nb_reg-1:0] in_if_id_rs;
  logic [nb_reg-1:0] in_if_id_rt;
  logic              in_branch_taken;
  logic              in_jump;
  logic              out_pc_enable;
  logic              out_if_id_enable;
  logic              out_if_id_flush;
  logic              out_id_ex_bubble;
  logic [1:0]        out_state;
  logic [len-1:0]    out_cycle_count;
  logic              out_done;

  // Datapath / debug side that drives requests and observes controls
  modport master (
    output in_mode_step, in_run, in_step, in_halt, in_id_ex_mem_read,
           in_id_ex_rt, in_if_id_rs, in_if_id_rt, in_branch_taken, in_jump,
    input  out_pc_enable, out_if_id_enable, out_if_id_flush,
           out_id_ex_bubble, out_state, out_cycle_count, out_done
  );

  // Controller side
  modport slave (
    input  in_mode_step, in_run, in_step, in_halt, in_id_ex_mem_read,
           in_id_ex_rt, in_if_id_rs, in_if_id_rt, in_branch_taken, in_jump,
    output out_pc_enable, out_if_id_enable, out_if_id_flush,
           out_id_ex_bubble, out_state, out_cycle_count, out_done
  );
endinterface

// File: rtl/pipeline_controller.sv
// Run/step/halt controller for a 5-stage pipeline with load-use stall
// detection and branch/jump flush generation. Counts advance cycles.
module pipeline_controller #(
  parameter int len    = 32,
  parameter int nb_reg = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_controller_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t         state_reg;
  logic [len-1:0] count_reg;
  logic           done_reg;
  logic           adv;
  logic           stall;
  logic           pc_enable;

  // Pipeline advances only while running or stepping; a load in ID/EX whose
  // destination feeds the IF/ID instruction forces a one-cycle stall.
  always_comb begin
    adv       = (state_reg == RUN) || (state_reg == STEP);
    stall     = adv && bus.in_id_ex_mem_read && (bus.in_id_ex_rt != '0) &&
                ((bus.in_id_ex_rt == bus.in_if_id_rs) ||
                 (bus.in_id_ex_rt == bus.in_if_id_rt));
    pc_enable = adv && !stall;
  end

  // Control outputs: stall suppresses the flush so the bubbled instruction
  // is not lost; the flush reappears once the hazard clears.
  always_comb begin
    bus.out_pc_enable    = pc_enable;
    bus.out_if_id_enable = pc_enable;
    bus.out_if_id_flush  = pc_enable && (bus.in_branch_taken || bus.in_jump);
    bus.out_id_ex_bubble = stall;
    bus.out_state        = state_reg;
    bus.out_cycle_count  = count_reg;
    bus.out_done         = done_reg;
  end

  // State machine and advance counter; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      if (adv)
        count_reg <= count_reg + len'(1);
      case (state_reg)
        IDLE: begin
          if (bus.in_mode_step && bus.in_step)
            state_reg <= STEP;
          else if (!bus.in_mode_step && bus.in_run)
            state_reg <= RUN;
        end
        RUN: begin
          if (bus.in_halt) begin
            state_reg <= HALTED;
            done_reg  <= 1'b1;
          end
        end
        STEP: begin
          if (bus.in_halt) begin
            state_reg <= HALTED;
            done_reg  <= 1'b1;
          end else if (pc_enable) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= HALTED;
          done_reg  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench: the driver applies one stimulus per cycle, predicts the
// controller's outputs from a behavioural model and queues them; a monitor
// compares the DUT against the queue on every falling edge.
module tb_pipeline_controller;
  localparam int LEN = 8;
  localparam int NB  = 3;

  typedef struct {
    bit       reset;
    bit       mode_step, run, step, halt, mem_read, br, jmp;
    int       ex_rt, rs, rt;
  } stim_t;

  typedef struct {
    bit pc_en, ifid_en, flush, bubble, done;
    int state, count;
  } exp_t;

  logic clk = 0;
  logic reset;
  pipeline_controller_if #(.len(LEN), .nb_reg(NB)) bus ();

  pipeline_controller #(.len(LEN), .nb_reg(NB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   txn   = 0;

  // Reference model: state as a small integer, counter as plain modular int
  int m_state = 0;
  int m_count = 0;

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d (txn %0d)", name, got, want, txn);
    end
  endtask

  // One clock cycle of stimulus with its predicted response
  task automatic cycle(input stim_t s);
    exp_t e;
    bit   adv, hz;
    @(posedge clk);
    #1;
    reset                 = s.reset;
    bus.in_mode_step      = s.mode_step;
    bus.in_run            = s.run;
    bus.in_step           = s.step;
    bus.in_halt           = s.halt;
    bus.in_id_ex_mem_read = s.mem_read;
    bus.in_id_ex_rt       = NB'(s.ex_rt);
    bus.in_if_id_rs       = NB'(s.rs);
    bus.in_if_id_rt       = NB'(s.rt);
    bus.in_branch_taken   = s.br;
    bus.in_jump           = s.jmp;

    adv      = (m_state == 1) || (m_state == 2);
    hz       = adv && s.mem_read && s.ex_rt != 0 &&
               (s.ex_rt == s.rs || s.ex_rt == s.rt);
    e.pc_en  = adv && !hz;
    e.ifid_en = adv && !hz;
    e.flush  = adv && !hz && (s.br || s.jmp);
    e.bubble = hz;
    e.state  = m_state;
    e.count  = m_count;
    e.done   = (m_state == 3);
    exp_q.push_back(e);

    if (s.reset) begin
      m_state = 0;
      m_count = 0;
    end else begin
      if (adv) m_count = (m_count + 1) % (1 << LEN);
      if (m_state == 0) begin
        if (s.mode_step) begin
          if (s.step) m_state = 2;
        end else if (s.run) m_state = 1;
      end else if (m_state == 1) begin
        if (s.halt) m_state = 3;
      end else if (m_state == 2) begin
        if (s.halt) m_state = 3;
        else if (e.pc_en) m_state = 0;
      end
    end
  endtask

  // Monitor: every cycle with a queued expectation is compared field by field
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      txn++;
      check("state",       int'(bus.out_state),        e.state);
      check("pc_enable",   int'(bus.out_pc_enable),    int'(e.pc_en));
      check("if_id_en",    int'(bus.out_if_id_enable), int'(e.ifid_en));
      check("flush",       int'(bus.out_if_id_flush),  int'(e.flush));
      check("bubble",      int'(bus.out_id_ex_bubble), int'(e.bubble));
      check("done",        int'(bus.out_done),         int'(e.done));
      check("cycle_count", int'(bus.out_cycle_count),  e.count);
      $display("txn %0d st=%0d pc=%0b fl=%0b bub=%0b done=%0b cnt=%0d",
               txn, bus.out_state, bus.out_pc_enable, bus.out_if_id_flush,
               bus.out_id_ex_bubble, bus.out_done, bus.out_cycle_count);
    end
  end

  function automatic stim_t quiet();
    stim_t s;
    s.reset = 0; s.mode_step = 0; s.run = 0; s.step = 0; s.halt = 0;
    s.mem_read = 0; s.br = 0; s.jmp = 0; s.ex_rt = 0; s.rs = 0; s.rt = 0;
    return s;
  endfunction

  // Independent spot check of an absolute value in the current cycle
  task automatic anchor(input string name, input int want);
    @(negedge clk);
    #1;
    check(name, int'(bus.out_cycle_count), want);
  endtask

  initial begin
    stim_t s;
    reset = 1;
    bus.in_mode_step = 0; bus.in_run = 0; bus.in_step = 0; bus.in_halt = 0;
    bus.in_id_ex_mem_read = 0; bus.in_id_ex_rt = '0; bus.in_if_id_rs = '0;
    bus.in_if_id_rt = '0; bus.in_branch_taken = 0; bus.in_jump = 0;
    repeat (2) @(posedge clk);
    m_state = 0;
    m_count = 0;

    // Continuous run, 10 clean cycles
    s = quiet(); s.reset = 1; cycle(s);
    s = quiet(); s.run = 1; cycle(s);
    for (int i = 0; i < 10; i++) begin s = quiet(); cycle(s); end
    // Load-use hazard, then same with destination r0
    s = quiet(); s.mem_read = 1; s.ex_rt = 5; s.rs = 5; cycle(s);
    anchor("count_after_run10", 10);
    s = quiet(); s.mem_read = 1; s.ex_rt = 0; s.rs = 0; cycle(s);
    // Branch together with hazard, then branch alone
    s = quiet(); s.br = 1; s.mem_read = 1; s.ex_rt = 3; s.rt = 3; cycle(s);
    s = quiet(); s.br = 1; cycle(s);
    // Halt, then run/step requests are ignored
    s = quiet(); s.halt = 1; cycle(s);
    for (int i = 0; i < 3; i++) begin
      s = quiet(); s.run = 1; s.step = 1; cycle(s);
    end
    s = quiet(); s.reset = 1; s.run = 1; cycle(s);
    s = quiet(); cycle(s);
    anchor("count_after_reset", 0);

    // Single step with a stall on the first STEP cycle
    s = quiet(); s.mode_step = 1; s.step = 1; s.run = 1; cycle(s);
    s = quiet(); s.mode_step = 1; s.mem_read = 1; s.ex_rt = 2; s.rs = 2; cycle(s);
    s = quiet(); s.mode_step = 1; cycle(s);
    s = quiet(); s.mode_step = 1; cycle(s);
    anchor("count_after_step", 2);

    // Counter wrap: 256 advances from zero
    s = quiet(); s.reset = 1; cycle(s);
    s = quiet(); s.run = 1; cycle(s);
    for (int i = 0; i < 255; i++) begin s = quiet(); cycle(s); end
    s = quiet(); cycle(s);
    anchor("count_max", 255);
    s = quiet(); cycle(s);
    anchor("count_wrap", 0);

    // Randomized traffic
    s = quiet(); s.reset = 1; cycle(s);
    for (int i = 0; i < 1500; i++) begin
      s.reset     = ($urandom_range(0, 99) < 3);
      s.mode_step = $urandom_range(0, 1);
      s.run       = ($urandom_range(0, 3) == 0);
      s.step      = ($urandom_range(0, 2) == 0);
      s.halt      = ($urandom_range(0, 99) < 2);
      s.mem_read  = $urandom_range(0, 1);
      s.ex_rt     = $urandom_range(0, 7);
      s.rs        = ($urandom_range(0, 2) == 0) ? s.ex_rt : $urandom_range(0, 7);
      s.rt        = ($urandom_range(0, 2) == 0) ? s.ex_rt : $urandom_range(0, 7);
      s.br        = ($urandom_range(0, 4) == 0);
      s.jmp       = ($urandom_range(0, 6) == 0);
      cycle(s);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
